// File: rtl/postcode_pkg.sv
// postcode_pkg: shared state encoding, error bit indices and byte width for the POST link
package postcode_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ONE, S_ZERO, S_OPOLL, S_IPOLL, S_IBIT, S_IEND} state_t;
  localparam int ERR_OVERRUN = 0;
  localparam int ERR_FRAME = 1;
  localparam int ERR_ABORT = 2;
  localparam int POST_BYTE_BITS = 8;
endpackage

// File: rtl/postcode_fifo.sv
// postcode_fifo: first-word fall-through FIFO with level and full-with-pop pass-through
module postcode_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [$clog2(DEPTH):0] o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [LW-1:0] r_level;
  logic w_push, w_pop;
  assign w_pop = i_ready & o_valid;
  assign o_valid = r_level != '0;
  assign o_ready = (r_level != LW'(DEPTH)) | w_pop;
  assign w_push = i_valid & o_ready;
  assign o_data = r_mem[r_rd];
  assign o_level = r_level;
  // storage array, written on accepted push
  always_ff @(posedge i_clk)
    if (w_push) r_mem[r_wr] <= i_data;
  // pointers and occupancy
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
      r_level <= '0;
    end else begin
      r_wr <= r_wr + AW'(w_push);
      r_rd <= r_rd + AW'(w_pop);
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
    end
endmodule

// File: rtl/postcode_link.sv
// postcode_link: RISC OS POST pulse-train decoder with buffered RX/TX byte streams
module postcode_link #(
  parameter int REFCLK_FREQ = 48000000,
  parameter int TIMER_MAX = 480,
  parameter int SYNC_STAGES = 3,
  parameter int RX_DEPTH = 16,
  parameter int TX_DEPTH = 16
) (
  input  logic                      i_refclk,
  input  logic                      i_rst_n,
  input  logic                      i_testreq,
  output logic                      o_testack,
  output logic [7:0]                o_rx_data,
  output logic                      o_rx_valid,
  input  logic                      i_rx_ready,
  input  logic [7:0]                i_tx_data,
  input  logic                      i_tx_valid,
  output logic                      o_tx_ready,
  output logic [$clog2(RX_DEPTH):0] o_rx_level,
  output logic [$clog2(TX_DEPTH):0] o_tx_level,
  output logic                      o_link_busy,
  output logic [2:0]                o_err_flags,
  input  logic                      i_err_clear
);
  import postcode_pkg::*;
  localparam int TW = $clog2(TIMER_MAX + 1);
  localparam int RXL = $clog2(RX_DEPTH) + 1;
  if (SYNC_STAGES < 2 || REFCLK_FREQ <= 0) begin : g_bad_param
    $error("postcode_link: SYNC_STAGES must be >=2 and REFCLK_FREQ positive");
  end
  logic [SYNC_STAGES-1:0] r_sync;
  logic r_req_q, r_ack;
  logic [TW-1:0] r_timer;
  state_t r_state;
  logic [6:0] r_rxshift, r_txshift;
  logic [3:0] r_rxbits;
  logic [2:0] r_bitidx, r_err;
  logic w_req_s, w_edge, w_gap, w_rx_push, w_rx_in_ready, w_tx_pop, w_tx_valid;
  logic w_overrun, w_frame, w_abort;
  logic [7:0] w_rx_byte, w_tx_data;
  assign w_req_s = r_sync[SYNC_STAGES-1];
  assign w_edge = w_req_s & ~r_req_q;
  assign w_gap = ~w_req_s & (r_timer == TW'(TIMER_MAX - 1));
  assign w_rx_byte = {r_rxshift, r_state == S_ONE};
  assign w_rx_push = w_gap & (r_state == S_ONE || r_state == S_ZERO) & (r_rxbits == 4'(POST_BYTE_BITS - 1));
  assign w_overrun = w_rx_push & ~w_rx_in_ready;
  assign w_frame = w_gap & (r_state == S_OPOLL) & (r_rxbits != '0);
  assign w_abort = w_gap & (r_state == S_IBIT) & (r_bitidx != '0);
  assign w_tx_pop = w_edge & (r_state == S_IPOLL) & r_ack;
  assign o_testack = i_testreq & r_ack & w_req_s;
  assign o_link_busy = r_state != S_IDLE;
  assign o_err_flags = r_err;
  // testreq synchroniser, edge history and inter-burst gap timer
  always_ff @(posedge i_refclk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_sync <= '0;
      r_req_q <= 1'b0;
      r_timer <= TW'(TIMER_MAX);
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_testreq};
      r_req_q <= w_req_s;
      r_timer <= w_req_s ? '0 : (r_timer == TW'(TIMER_MAX) ? r_timer : r_timer + 1'b1);
    end
  // pulse FSM: one step per rising edge, gap closes the burst and commits RX bits
  always_ff @(posedge i_refclk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_ack <= 1'b0;
      r_rxshift <= '0;
      r_rxbits <= '0;
      r_txshift <= '0;
      r_bitidx <= '0;
    end else if (w_gap) begin
      r_state <= S_IDLE;
      if (r_state == S_ONE || r_state == S_ZERO) begin
        r_rxshift <= w_rx_byte[6:0];
        r_rxbits <= w_rx_push ? '0 : r_rxbits + 1'b1;
      end
      if (r_state == S_OPOLL) r_rxbits <= '0;
    end else if (w_edge) begin
      case (r_state)
        S_IDLE: begin r_state <= S_ONE; r_ack <= 1'b1; end
        S_ONE: begin r_state <= S_ZERO; r_ack <= 1'b1; end
        S_ZERO: begin r_state <= S_OPOLL; r_ack <= o_rx_level < RXL'(RX_DEPTH); end
        S_OPOLL: begin r_state <= S_IPOLL; r_ack <= w_tx_valid; end
        S_IPOLL:
          if (r_ack) begin
            r_txshift <= w_tx_data[6:0];
            r_ack <= w_tx_data[7];
            r_bitidx <= 3'(POST_BYTE_BITS - 2);
            r_state <= S_IBIT;
          end else r_ack <= w_tx_valid;
        S_IBIT: begin
          r_ack <= r_txshift[r_bitidx];
          r_bitidx <= r_bitidx - 1'b1;
          if (r_bitidx == '0) r_state <= S_IEND;
        end
        S_IEND: begin r_state <= S_IPOLL; r_ack <= w_tx_valid; end
        default: r_state <= S_IDLE;
      endcase
    end
  // sticky error flags; a new error in the clear cycle survives
  always_ff @(posedge i_refclk or negedge i_rst_n)
    if (!i_rst_n) r_err <= '0;
    else begin
      r_err <= (i_err_clear ? '0 : r_err) | {w_abort, w_frame, w_overrun};
    end
  postcode_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .i_clk(i_refclk), .i_rst_n(i_rst_n),
    .i_data(w_rx_byte), .i_valid(w_rx_push), .o_ready(w_rx_in_ready),
    .o_data(o_rx_data), .o_valid(o_rx_valid), .i_ready(i_rx_ready),
    .o_level(o_rx_level)
  );
  postcode_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .i_clk(i_refclk), .i_rst_n(i_rst_n),
    .i_data(i_tx_data), .i_valid(i_tx_valid), .o_ready(o_tx_ready),
    .o_data(w_tx_data), .o_valid(w_tx_valid), .i_ready(w_tx_pop),
    .o_level(o_tx_level)
  );
endmodule
